dmem_lsu: RTL

- Load/store unit between the CPU datapath and the byte-array data memory (dmem).
- Accepts one load or store request per valid/ready handshake and drives the dmem address, data, size and write-enable for exactly one access cycle.
- For loads, extracts the byte or halfword from the returned word and sign- or zero-extends it. Returns a registered response with a fault indication.
- Bit numbering is big-endian throughout: [0:31], bit 0 is the MSB.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_load_extend.sv | 24 ++
 rtl/dmem_lsu.sv | 104 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and request-classification helpers for the dmem load/store unit.
// Bit numbering is big-endian: [0:31], bit 0 is the MSB.
package lsu_pkg;

    typedef logic [0:1] dsize_t;
    typedef logic [0:1] fault_t;

    localparam dsize_t DSIZE_BYTE = 2'd0;
    localparam dsize_t DSIZE_HALF = 2'd1;
    localparam dsize_t DSIZE_WORD = 2'd3;

    localparam fault_t FAULT_NONE     = 2'd0;
    localparam fault_t FAULT_MISALIGN = 2'd1;
    localparam fault_t FAULT_RANGE    = 2'd2;
    localparam fault_t FAULT_SIZE     = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Highest-priority fault first; the end address is formed in 33 bits so it cannot wrap.
    function automatic fault_t lsu_classify(input logic [0:31] addr, input dsize_t size,
                                            input bit align_check, input int unsigned mem_size);
        logic [32:0] w_end;
        w_end = {1'b0, addr} + {31'd0, size} + 33'd1;
        if (size == 2'd2)
            return FAULT_SIZE;
        if (align_check && ((size == DSIZE_HALF && addr[31]) ||
                            (size == DSIZE_WORD && addr[30:31] != 2'b00)))
            return FAULT_MISALIGN;
        if (w_end > {1'b0, mem_size})
            return FAULT_RANGE;
        return FAULT_NONE;
    endfunction

    function automatic logic [0:31] lsu_wdata_align(input logic [0:31] d, input dsize_t size);
        case (size)
            DSIZE_BYTE: return {24'd0, d[24:31]};
            DSIZE_HALF: return {16'd0, d[16:31]};
            default:    return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the byte/halfword/word at the top of the dmem read word and sign- or zero-extends it.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [0:31] i_rdata,
    input  dsize_t      i_size,
    input  logic        i_signed,
    output logic [0:31] o_data
);

    logic w_sign;
    assign w_sign = i_signed & i_rdata[0];

    always_comb begin
        // NOTE: default assignment first so every path drives o_data and no latch is inferred.
        o_data = i_rdata;
        case (i_size)
            DSIZE_BYTE: o_data = {{24{w_sign}}, i_rdata[0:7]};
            DSIZE_HALF: o_data = {{16{w_sign}}, i_rdata[0:15]};
            default:    o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one request per handshake, one dmem access cycle, registered response.
// Faulting requests skip the access cycle and never touch memory.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE    = 32768,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [0:1]  req_size,
    input  logic        req_signed,
    input  logic [0:31] req_addr,
    input  logic [0:31] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [0:31] resp_rdata,
    output logic        resp_fault,
    output logic [0:1]  resp_fault_code,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wData,
    output logic        mem_writeEnable,
    output logic [0:1]  mem_dsize,
    input  logic [0:31] mem_rData
);

    logic [1:0]  r_state;
    logic        r_write;
    logic        r_signed;
    logic        w_accept;
    fault_t      w_fault;
    logic [0:31] w_load;

    assign req_ready = (r_state == ST_IDLE) || (r_state == ST_RESP && resp_ready);
    assign w_accept  = req_valid & req_ready;
    assign w_fault   = lsu_classify(req_addr, req_size, ALIGN_CHECK, MEM_SIZE);

    lsu_load_extend u_load_extend (
        .i_rdata  (mem_rData),
        .i_size   (mem_dsize),
        .i_signed (r_signed),
        .o_data   (w_load)
    );

    // NOTE: the write strobe is a flop on the async reset, so reset removes it mid-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_write         <= 1'b0;
            r_signed        <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_fault      <= 1'b0;
            resp_fault_code <= FAULT_NONE;
            mem_addr        <= '0;
            mem_wData       <= '0;
            mem_writeEnable <= 1'b0;
            mem_dsize       <= DSIZE_BYTE;
        end else begin
            mem_writeEnable <= 1'b0;

            case (r_state)
                ST_ACCESS: begin
                    r_state         <= ST_RESP;
                    resp_valid      <= 1'b1;
                    resp_fault      <= 1'b0;
                    resp_fault_code <= FAULT_NONE;
                    resp_rdata      <= r_write ? '0 : w_load;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state    <= ST_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                ST_IDLE: ;
                default: r_state <= ST_IDLE;
            endcase

            // A new request overrides the IDLE/RESP bookkeeping above.
            if (w_accept) begin
                r_write  <= req_write;
                r_signed <= req_signed;
                if (w_fault != FAULT_NONE) begin
                    r_state         <= ST_RESP;
                    resp_valid      <= 1'b1;
                    resp_fault      <= 1'b1;
                    resp_fault_code <= w_fault;
                    resp_rdata      <= '0;
                end else begin
                    r_state         <= ST_ACCESS;
                    mem_addr        <= req_addr;
                    mem_dsize       <= req_size;
                    mem_wData       <= lsu_wdata_align(req_wdata, req_size);
                    mem_writeEnable <= req_write;
                end
            end
        end
    end

endmodule
